// File: rtl/priv_1_12_clint.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// priv_1_12_clint
//
// Machine-level core-local interruptor. Holds the memory-mapped msip, mtimecmp
// and mtime registers and turns changes of the timer condition and of msip
// into one-cycle set/clear pulses for the privilege unit's interrupt handler,
// which keeps the pending state in mip. mtime is also exported for the
// time/timeh CSRs.
//
// Register map (32-bit words, addr[1:0] ignored):
//   0x0000 msip (bit0), 0x4000/0x4004 mtimecmp lo/hi, 0xBFF8/0xBFFC mtime lo/hi.
//   Unmapped offsets read 0, ignore writes, and still complete with ready.
//
// Bus handshake: a request (ren|wen) seen in IDLE during cycle N is accepted;
// any write lands at the clock edge ending N. In cycle N+1 (RESP) ready is a
// one-cycle pulse and rdata carries the value sampled in cycle N. Requests
// present during RESP are ignored; the master drops ren/wen on ready. ren and
// wen together perform the write only and return rdata=0. rdata is 0 whenever
// ready is 0.
//
// Optional feature: define CLINT_PRESCALE_EN to make mtime advance once every
// TICK_DIV cycles through a 16-bit prescale counter. Without it mtime advances
// every cycle and TICK_DIV has no effect.
//
// Ports:
//   CLK, nRST             clock, asynchronous active-low reset
//   addr, ren, wen, wdata register bus request
//   rdata, ready          register bus response
//   timer_int_m           pulse: mtime >= mtimecmp became true
//   clear_timer_int_m     pulse: mtime >= mtimecmp became false
//   soft_int_m            pulse: msip written 0->1
//   clear_soft_int_m      pulse: msip written 1->0
//   mtime_o               current mtime
// -----------------------------------------------------------------------------
module priv_1_12_clint #(
  parameter int          BASE_ADDR_W  = 16,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          TICK_DIV     = 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [BASE_ADDR_W-1:0] addr,
  input  logic                   ren,
  input  logic                   wen,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   timer_int_m,
  output logic                   clear_timer_int_m,
  output logic                   soft_int_m,
  output logic                   clear_soft_int_m,
  output logic [63:0]            mtime_o
);

  localparam logic [BASE_ADDR_W-1:0] OFF_MSIP     = BASE_ADDR_W'(16'h0000);
  localparam logic [BASE_ADDR_W-1:0] OFF_CMP_LO   = BASE_ADDR_W'(16'h4000);
  localparam logic [BASE_ADDR_W-1:0] OFF_CMP_HI   = BASE_ADDR_W'(16'h4004);
  localparam logic [BASE_ADDR_W-1:0] OFF_MTIME_LO = BASE_ADDR_W'(16'hBFF8);
  localparam logic [BASE_ADDR_W-1:0] OFF_MTIME_HI = BASE_ADDR_W'(16'hBFFC);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_e;

  bus_state_e state_q, state_d;

  logic [BASE_ADDR_W-1:0] word_addr;
  logic                   sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mtime_lo, sel_mtime_hi;
  logic                   req, wr, rd;
  logic [31:0]            rd_mux;
  logic [31:0]            rdata_q;

  logic                   msip_q;
  logic                   soft_set_q, soft_clr_q;
  logic [63:0]            mtimecmp_q;
  logic [63:0]            mtime_q, mtime_d;
  logic                   tick;
  logic                   cond, cond_q;
  logic                   timer_set_q, timer_clr_q;

  logic                   unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  // Byte offset with the sub-word bits forced to zero.
  assign word_addr    = {addr[BASE_ADDR_W-1:2], 2'b00};
  assign sel_msip     = (word_addr == OFF_MSIP);
  assign sel_cmp_lo   = (word_addr == OFF_CMP_LO);
  assign sel_cmp_hi   = (word_addr == OFF_CMP_HI);
  assign sel_mtime_lo = (word_addr == OFF_MTIME_LO);
  assign sel_mtime_hi = (word_addr == OFF_MTIME_HI);

  assign req = (state_q == IDLE) && (ren || wen);
  assign wr  = req && wen;
  assign rd  = req && ren && !wen;

  // ---------------------------------------------------------------------------
  // Bus FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ren || wen) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == RESP);
    rdata = ready ? rdata_q : 32'd0;
  end

  // ---------------------------------------------------------------------------
  // Read path: value sampled in the request cycle, presented in RESP.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = 32'd0;
    if (sel_msip)          rd_mux = {31'd0, msip_q};
    else if (sel_cmp_lo)   rd_mux = mtimecmp_q[31:0];
    else if (sel_cmp_hi)   rd_mux = mtimecmp_q[63:32];
    else if (sel_mtime_lo) rd_mux = mtime_q[31:0];
    else if (sel_mtime_hi) rd_mux = mtime_q[63:32];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)    rdata_q <= 32'd0;
    else if (req) rdata_q <= rd ? rd_mux : 32'd0;
  end

  // ---------------------------------------------------------------------------
  // msip and its edge pulses. The pulse registers are written every cycle so
  // they land in RESP together with ready and drop the cycle after.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      msip_q     <= 1'b0;
      soft_set_q <= 1'b0;
      soft_clr_q <= 1'b0;
    end else begin
      soft_set_q <= wr && sel_msip && wdata[0] && !msip_q;
      soft_clr_q <= wr && sel_msip && !wdata[0] && msip_q;
      if (wr && sel_msip) msip_q <= wdata[0];
    end
  end

  // ---------------------------------------------------------------------------
  // mtimecmp
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mtimecmp_q <= MTIMECMP_RST;
    end else if (wr) begin
      if (sel_cmp_lo) mtimecmp_q[31:0]  <= wdata;
      if (sel_cmp_hi) mtimecmp_q[63:32] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // mtime tick source
  // ---------------------------------------------------------------------------
`ifdef CLINT_PRESCALE_EN
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc_q;

  assign tick = (presc_q == TICK_LAST);

  // A write to either half of mtime restarts the prescale period.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                  presc_q <= 16'd0;
    else if (wr && (sel_mtime_lo || sel_mtime_hi)) presc_q <= 16'd0;
    else if (tick)                              presc_q <= 16'd0;
    else                                        presc_q <= presc_q + 16'd1;
  end
`else
  logic [15:0] unused_tick_div;

  assign unused_tick_div = 16'(TICK_DIV);
  assign tick            = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // mtime. A half-write replaces the increment for that cycle: the written
  // half takes wdata and the other half keeps its old value (no carry).
  // ---------------------------------------------------------------------------
  always_comb begin
    mtime_d = mtime_q;
    if (wr && sel_mtime_lo)      mtime_d = {mtime_q[63:32], wdata};
    else if (wr && sel_mtime_hi) mtime_d = {wdata, mtime_q[31:0]};
    else if (tick)               mtime_d = mtime_q + 64'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) mtime_q <= 64'd0;
    else       mtime_q <= mtime_d;
  end

  assign mtime_o = mtime_q;

  // ---------------------------------------------------------------------------
  // Timer condition and its edge pulses. Both pulses are registered, so a
  // register change that flips cond at the edge ending cycle N shows up as a
  // pulse in cycle N+2.
  // ---------------------------------------------------------------------------
  assign cond = (mtime_q >= mtimecmp_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cond_q      <= 1'b0;
      timer_set_q <= 1'b0;
      timer_clr_q <= 1'b0;
    end else begin
      cond_q      <= cond;
      timer_set_q <= cond && !cond_q;
      timer_clr_q <= !cond && cond_q;
    end
  end

  assign timer_int_m       = timer_set_q;
  assign clear_timer_int_m = timer_clr_q;
  assign soft_int_m        = soft_set_q;
  assign clear_soft_int_m  = soft_clr_q;

endmodule

// File: tb/tb_priv_1_12_clint.sv
`timescale 1ns/1ps
module tb_priv_1_12_clint;

`ifdef CLINT_PRESCALE_EN
  localparam int TB_TICK_DIV = 4;
`else
  localparam int TB_TICK_DIV = 1;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        CLK = 1'b0;
  logic        nRST;
  logic [15:0] addr;
  logic        ren, wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        timer_int_m, clear_timer_int_m, soft_int_m, clear_soft_int_m;
  logic [63:0] mtime_o;

  always #5 CLK = ~CLK;

  priv_1_12_clint #(
    .BASE_ADDR_W (16),
    .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF),
    .TICK_DIV    (TB_TICK_DIV)
  ) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .addr             (addr),
    .ren              (ren),
    .wen              (wen),
    .wdata            (wdata),
    .rdata            (rdata),
    .ready            (ready),
    .timer_int_m      (timer_int_m),
    .clear_timer_int_m(clear_timer_int_m),
    .soft_int_m       (soft_int_m),
    .clear_soft_int_m (clear_soft_int_m),
    .mtime_o          (mtime_o)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference mtime: reset to 0, advances on each prescale wrap, half-writes
  // replace the advance for that cycle and restart the prescale period.
  logic [63:0] m_mtime;
  logic [15:0] m_cnt;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_mtime <= 64'd0;
      m_cnt   <= 16'd0;
    end else if (wen && addr == 16'hBFF8) begin
      m_mtime[31:0] <= wdata;
      m_cnt         <= 16'd0;
    end else if (wen && addr == 16'hBFFC) begin
      m_mtime[63:32] <= wdata;
      m_cnt          <= 16'd0;
    end else if (m_cnt == 16'(TB_TICK_DIV - 1)) begin
      m_cnt   <= 16'd0;
      m_mtime <= m_mtime + 64'd1;
    end else begin
      m_cnt <= m_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard queues
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  logic [1:0]  exp_p_q[$];   // {soft_int_m, clear_soft_int_m} expected with ready
  int          exp_c_q[$];   // issue cycle
  string       exp_n_q[$];
  int          tset_q[$];    // cycle of expected timer_int_m
  int          tclr_q[$];    // cycle of expected clear_timer_int_m
  logic [31:0] last_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (nRST) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_ready", {32'd0, rdata});
        end else begin
          logic [31:0] e;
          logic [1:0]  p;
          int          c;
          string       n;
          e = exp_q.pop_front();
          p = exp_p_q.pop_front();
          c = exp_c_q.pop_front();
          n = exp_n_q.pop_front();
          chk({n, "_rdata"}, {32'd0, rdata}, {32'd0, e});
          chk({n, "_latency"}, 64'(cyc - c), 64'd1);
          chk({n, "_soft"}, {62'd0, soft_int_m, clear_soft_int_m}, {62'd0, p});
        end
        last_rdata = rdata;
      end else begin
        if (rdata !== 32'd0) chk("rdata_idle", {32'd0, rdata}, 64'd0);
        if (soft_int_m || clear_soft_int_m)
          flag("soft_without_ready", {62'd0, soft_int_m, clear_soft_int_m});
      end
      if (timer_int_m) begin
        if (tset_q.size() == 0) flag("unexpected_timer_int", 64'(cyc));
        else chk("timer_int_cycle", 64'(cyc), 64'(tset_q.pop_front()));
      end
      if (clear_timer_int_m) begin
        if (tclr_q.size() == 0) flag("unexpected_clear_timer_int", 64'(cyc));
        else chk("clear_timer_int_cycle", 64'(cyc), 64'(tclr_q.pop_front()));
      end
      chk("mtime_o", mtime_o, m_mtime);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: entered and left on a falling edge; one access takes
  // two cycles (request, response).
  // ---------------------------------------------------------------------------
  task automatic bus_op(input string name, input logic w, input logic r,
                        input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic [1:0] exp_p);
    exp_q.push_back(exp_rd);
    exp_p_q.push_back(exp_p);
    exp_c_q.push_back(cyc);
    exp_n_q.push_back(name);
    wen = w; ren = r; addr = a; wdata = d;
    @(posedge CLK); #1;
    wen = 1'b0; ren = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic rd_op(input string name, input logic [15:0] a, input logic [31:0] exp_rd);
    bus_op(name, 1'b0, 1'b1, a, 32'd0, exp_rd, 2'b00);
  endtask

  task automatic wr_op(input string name, input logic [15:0] a, input logic [31:0] d,
                       input logic [1:0] exp_p);
    bus_op(name, 1'b1, 1'b0, a, d, 32'd0, exp_p);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] first;
    nRST = 1'b0; ren = 1'b0; wen = 1'b0; addr = 16'd0; wdata = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    chk("rst_pulses", {60'd0, timer_int_m, clear_timer_int_m, soft_int_m, clear_soft_int_m}, 64'd0);
    chk("rst_mtime", mtime_o, 64'd0);
    @(posedge CLK); #2;
    nRST = 1'b1;
    @(negedge CLK);

`ifdef CLINT_PRESCALE_EN
    rd_op("p_cmp_hi", 16'h4004, 32'hFFFF_FFFF);
    // Write lands at the edge ending N; mtime is 100 in N+1..N+4, 101 from N+5.
    wr_op("p_mtime_lo", 16'hBFF8, 32'd100, 2'b00);
    chk("p_mtime_n2", mtime_o, 64'd100);
    repeat (2) @(negedge CLK);
    chk("p_mtime_n4", mtime_o, 64'd100);
    @(negedge CLK);
    chk("p_mtime_n5", mtime_o, 64'd101);
    repeat (4) @(negedge CLK);
    chk("p_mtime_n9", mtime_o, 64'd102);
    rd_op("p_mtime_rd", 16'hBFF8, m_mtime[31:0]);
`else
    // mtime read twice, five cycles apart.
    rd_op("mtime_rd0", 16'hBFF8, m_mtime[31:0]);
    first = last_rdata;
    repeat (3) @(negedge CLK);
    rd_op("mtime_rd1", 16'hBFF8, m_mtime[31:0]);
    chk("mtime_delta5", {32'd0, last_rdata - first}, 64'd5);
    rd_op("cmp_hi_rst", 16'h4004, 32'hFFFF_FFFF);

    // Timer set: mtime:=0 at W (0 in W+1), cmp hi at W+2, cmp lo=20 at N=W+4
    // with mtime=3. mtime reaches 20 in N+17 -> pulse in N+18.
    wr_op("mtime_lo0", 16'hBFF8, 32'd0, 2'b00);
    wr_op("cmp_hi0", 16'h4004, 32'd0, 2'b00);
    tset_q.push_back(cyc + 18);
    wr_op("cmp_lo20", 16'h4000, 32'd20, 2'b00);
    repeat (20) @(negedge CLK);
    // Raising compare: cond false from N+1 -> clear pulse in N+2.
    tclr_q.push_back(cyc + 2);
    wr_op("cmp_lo_ones", 16'h4000, 32'hFFFF_FFFF, 2'b00);
    wr_op("cmp_hi_ones", 16'h4004, 32'hFFFF_FFFF, 2'b00);
    rd_op("cmp_lo_rd", 16'h4000, 32'hFFFF_FFFF);

    // msip edges.
    wr_op("msip_set", 16'h0000, 32'd1, 2'b10);
    rd_op("msip_rd1", 16'h0000, 32'd1);
    wr_op("msip_same", 16'h0000, 32'd1, 2'b00);
    wr_op("msip_clr", 16'h0000, 32'hFFFF_FFFE, 2'b01);
    rd_op("msip_rd0", 16'h0000, 32'd0);

    // Wrap: hi=ones, then lo=ones at N -> all ones in N+1, 0 in N+2. Against
    // an all-ones compare this gives a set pulse at N+2 and a clear at N+3.
    wr_op("mtime_hi_ones", 16'hBFFC, 32'hFFFF_FFFF, 2'b00);
    tset_q.push_back(cyc + 2);
    tclr_q.push_back(cyc + 3);
    wr_op("mtime_lo_ones", 16'hBFF8, 32'hFFFF_FFFF, 2'b00);
    chk("mtime_wrap0", mtime_o, 64'd0);
    @(negedge CLK);
    chk("mtime_wrap1", mtime_o, 64'd1);

    rd_op("unmapped", 16'h1234, 32'd0);
    bus_op("ren_wen_msip", 1'b1, 1'b1, 16'h0000, 32'd1, 32'd0, 2'b10);
    rd_op("msip_after_rw", 16'h0000, 32'd1);

    // Reset during RESP of a msip clear: no ready or pulse may follow.
    wr_op("cmp_hi_zero", 16'h4004, 32'd0, 2'b00);
    wen = 1'b1; addr = 16'h0000; wdata = 32'd0;
    @(posedge CLK); #1;
    wen = 1'b0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #2 nRST = 1'b1;
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    rd_op("post_rst_msip", 16'h0000, 32'd0);
    rd_op("post_rst_cmp_lo", 16'h4000, 32'hFFFF_FFFF);
    rd_op("post_rst_cmp_hi", 16'h4004, 32'hFFFF_FFFF);
    rd_op("post_rst_mtime_lo", 16'hBFF8, m_mtime[31:0]);
    rd_op("post_rst_mtime_hi", 16'hBFFC, 32'd0);
`endif

    repeat (5) @(negedge CLK);
    while (exp_q.size() > 0) begin
      flag({"missing_ready_", exp_n_q.pop_front()}, {32'd0, exp_q.pop_front()});
    end
    while (tset_q.size() > 0) flag("missing_timer_int", 64'(tset_q.pop_front()));
    while (tclr_q.size() > 0) flag("missing_clear_timer_int", 64'(tclr_q.pop_front()));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
